// File: rtl/branch_target_buffer_pkg.sv
// ============================================================================
// Module      : branch_target_buffer_pkg
// Description : Shared encodings for the BTB and its bimodal predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_target_buffer_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic [1:0] {
        PS_MISS_T  = 2'd0,
        PS_MISS_NT = 2'd1,
        PS_OK_NT   = 2'd2,
        PS_OK_T    = 2'd3
    } pred_status_e;

    localparam ctr_e CTR_RESET = WNT;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Next state of a 2-bit saturating counter given the outcome.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit bimodal counters; zero-latency
//               lookup, trained from EX resolution. Optional performance
//               counters are built when BTB_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter  int ENTRIES    = 64,
    localparam int INDEX_BITS = $clog2(ENTRIES),
    localparam int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_pc,
    output logic        BTBhit,
    output logic [1:0]  IF_branch_prediction,
    output logic [31:0] IF_pc_imm,
    output logic        IF_Branch,
    output logic        IF_Jump,
    input  logic        EX_valid,
    input  logic [31:0] EX_pc,
    input  logic        EX_Branch,
    input  logic        EX_Jump,
    input  logic        EX_ALUSrc,
    input  logic        EX_taken,
    input  logic [31:0] EX_pc_imm,
    input  logic [1:0]  EX_branch_prediction,
    output logic [1:0]  prediction_status
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] lookup_cnt,
    output logic [31:0] hit_cnt,
    output logic [31:0] mispredict_cnt
`endif
);

    logic                valid_q   [ENTRIES];
    logic [TAG_BITS-1:0] tag_q     [ENTRIES];
    logic [31:0]         target_q  [ENTRIES];
    logic                is_jump_q [ENTRIES];
    logic [1:0]          ctr_q     [ENTRIES];

    logic [INDEX_BITS-1:0] w_if_idx, w_ex_idx;
    logic [TAG_BITS-1:0]   w_if_tag, w_ex_tag;
    logic                  w_if_hit, w_ex_hit;
    logic [1:0]            w_ctr_trained;
    logic                  we_d;
    logic [31:0]           target_d;
    logic                  is_jump_d;
    logic [1:0]            ctr_d;
    logic                  w_unused_bits;

    assign w_unused_bits = ^{IF_pc[1:0], EX_pc[1:0], EX_branch_prediction[0]};

    assign w_if_idx = IF_pc[INDEX_BITS+1:2];
    assign w_if_tag = IF_pc[31:INDEX_BITS+2];
    assign w_ex_idx = EX_pc[INDEX_BITS+1:2];
    assign w_ex_tag = EX_pc[31:INDEX_BITS+2];

    // Outputs are forced to the miss pattern while reset is held.
    assign w_if_hit = !rst && valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
    assign w_ex_hit = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);

    assign BTBhit               = w_if_hit;
    assign IF_Branch            = w_if_hit && !is_jump_q[w_if_idx];
    assign IF_Jump              = w_if_hit && is_jump_q[w_if_idx];
    assign IF_pc_imm            = w_if_hit ? target_q[w_if_idx] : 32'd0;
    assign IF_branch_prediction = w_if_hit ? ctr_q[w_if_idx] : CTR_RESET;

    always_comb begin
        prediction_status = PS_OK_NT;
        if (EX_Branch) begin
            case ({EX_taken, EX_branch_prediction[1]})
                2'b10:   prediction_status = PS_MISS_T;
                2'b01:   prediction_status = PS_MISS_NT;
                2'b11:   prediction_status = PS_OK_T;
                default: prediction_status = PS_OK_NT;
            endcase
        end
    end

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[w_ex_idx]),
        .taken_i (EX_taken),
        .ctr_o   (w_ctr_trained)
    );

    // Branch has priority over jump when both are flagged.
    always_comb begin
        we_d      = 1'b0;
        target_d  = target_q[w_ex_idx];
        is_jump_d = 1'b0;
        ctr_d     = ctr_q[w_ex_idx];
        if (EX_valid) begin
            if (EX_Branch) begin
                if (w_ex_hit) begin
                    we_d  = 1'b1;
                    ctr_d = w_ctr_trained;
                    if (EX_taken) target_d = EX_pc_imm;
                end else if (EX_taken) begin
                    we_d     = 1'b1;
                    target_d = EX_pc_imm;
                    ctr_d    = WT;
                end
            end else if (EX_Jump && !EX_ALUSrc) begin
                we_d      = 1'b1;
                target_d  = EX_pc_imm;
                is_jump_d = 1'b1;
                ctr_d     = ST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= CTR_RESET;
            end
        end else if (we_d) begin
            valid_q[w_ex_idx]   <= 1'b1;
            tag_q[w_ex_idx]     <= w_ex_tag;
            target_q[w_ex_idx]  <= target_d;
            is_jump_q[w_ex_idx] <= is_jump_d;
            ctr_q[w_ex_idx]     <= ctr_d;
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] lookup_cnt_q, hit_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_cnt_q     <= '0;
            hit_cnt_q        <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_q + 32'd1;
            if (w_if_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (EX_valid && EX_Branch && !prediction_status[1])
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign lookup_cnt     = lookup_cnt_q;
    assign hit_cnt        = hit_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Directed vector bench for branch_target_buffer
//               (performance counters checked when BTB_PERF_CNT_EN is set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_pc;
    logic        BTBhit;
    logic [1:0]  IF_branch_prediction;
    logic [31:0] IF_pc_imm;
    logic        IF_Branch, IF_Jump;
    logic        EX_valid, EX_Branch, EX_Jump, EX_ALUSrc, EX_taken;
    logic [31:0] EX_pc, EX_pc_imm;
    logic [1:0]  EX_branch_prediction;
    logic [1:0]  prediction_status;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] lookup_cnt, hit_cnt, mispredict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .IF_pc                (IF_pc),
        .BTBhit               (BTBhit),
        .IF_branch_prediction (IF_branch_prediction),
        .IF_pc_imm            (IF_pc_imm),
        .IF_Branch            (IF_Branch),
        .IF_Jump              (IF_Jump),
        .EX_valid             (EX_valid),
        .EX_pc                (EX_pc),
        .EX_Branch            (EX_Branch),
        .EX_Jump              (EX_Jump),
        .EX_ALUSrc            (EX_ALUSrc),
        .EX_taken             (EX_taken),
        .EX_pc_imm            (EX_pc_imm),
        .EX_branch_prediction (EX_branch_prediction),
        .prediction_status    (prediction_status)
`ifdef BTB_PERF_CNT_EN
        ,
        .lookup_cnt           (lookup_cnt),
        .hit_cnt              (hit_cnt),
        .mispredict_cnt       (mispredict_cnt)
`endif
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        v, br, jp, src, tk;
        logic [31:0] ex_pc, imm;
        logic [1:0]  bp;
        logic        e_hit;
        logic [1:0]  e_bp;
        logic [31:0] e_imm;
        logic        e_br, e_jmp;
        logic [1:0]  e_ps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] if_pc, logic v, logic br, logic jp,
                                logic src, logic tk, logic [31:0] ex_pc,
                                logic [31:0] imm, logic [1:0] bp, logic e_hit,
                                logic [1:0] e_bp, logic [31:0] e_imm,
                                logic e_br, logic e_jmp, logic [1:0] e_ps);
        vec_t t;
        t.if_pc = if_pc; t.v = v; t.br = br; t.jp = jp; t.src = src; t.tk = tk;
        t.ex_pc = ex_pc; t.imm = imm; t.bp = bp; t.e_hit = e_hit; t.e_bp = e_bp;
        t.e_imm = e_imm; t.e_br = e_br; t.e_jmp = e_jmp; t.e_ps = e_ps;
        return t;
    endfunction

    function automatic vec_t idle(logic [31:0] if_pc, logic e_hit, logic [1:0] e_bp,
                                  logic [31:0] e_imm, logic e_br, logic e_jmp);
        return mk(if_pc, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00,
                  e_hit, e_bp, e_imm, e_br, e_jmp, 2'd2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_lookup(input string tag, input logic hit, input logic [1:0] bp,
                              input logic [31:0] imm, input logic br, input logic jmp);
        chk({tag, " BTBhit"}, {31'd0, BTBhit}, {31'd0, hit});
        chk({tag, " pred"}, {30'd0, IF_branch_prediction}, {30'd0, bp});
        chk({tag, " pc_imm"}, IF_pc_imm, imm);
        chk({tag, " IF_Branch"}, {31'd0, IF_Branch}, {31'd0, br});
        chk({tag, " IF_Jump"}, {31'd0, IF_Jump}, {31'd0, jmp});
    endtask

    task automatic drive_idle(input logic [31:0] pc);
        IF_pc = pc; EX_valid = 0; EX_Branch = 0; EX_Jump = 0; EX_ALUSrc = 0;
        EX_taken = 0; EX_pc = 0; EX_pc_imm = 0; EX_branch_prediction = 2'b00;
    endtask

    initial begin
        int exp_hits;
        int exp_misp;

        // Stimulus table: lookup is checked before the row's update edge.
        vecs.push_back(idle(32'h100, 0, 2'b01, 32'h0, 0, 0));
        vecs.push_back(mk(32'h100, 1,1,0,0,1, 32'h100, 32'h200, 2'b01, 0, 2'b01, 32'h0,   0,0, 2'd0));
        vecs.push_back(idle(32'h100, 1, 2'b10, 32'h200, 1, 0));
        vecs.push_back(mk(32'h100, 1,1,0,0,1, 32'h100, 32'h200, 2'b10, 1, 2'b10, 32'h200, 1,0, 2'd3));
        vecs.push_back(mk(32'h100, 1,1,0,0,1, 32'h100, 32'h200, 2'b11, 1, 2'b11, 32'h200, 1,0, 2'd3));
        vecs.push_back(mk(32'h100, 1,1,0,0,0, 32'h100, 32'h200, 2'b11, 1, 2'b11, 32'h200, 1,0, 2'd1));
        vecs.push_back(mk(32'h100, 1,1,0,0,0, 32'h100, 32'h999, 2'b10, 1, 2'b10, 32'h200, 1,0, 2'd1));
        vecs.push_back(mk(32'h100, 1,1,0,0,0, 32'h100, 32'h0,   2'b01, 1, 2'b01, 32'h200, 1,0, 2'd2));
        vecs.push_back(mk(32'h100, 1,1,0,0,0, 32'h100, 32'h0,   2'b00, 1, 2'b00, 32'h200, 1,0, 2'd2));
        vecs.push_back(mk(32'h100, 1,1,0,0,1, 32'h100, 32'h300, 2'b00, 1, 2'b00, 32'h200, 1,0, 2'd0));
        vecs.push_back(idle(32'h100, 1, 2'b01, 32'h300, 1, 0));
        vecs.push_back(mk(32'h400, 1,0,1,0,0, 32'h400, 32'h80,  2'b01, 0, 2'b01, 32'h0,   0,0, 2'd2));
        vecs.push_back(idle(32'h400, 1, 2'b11, 32'h80, 0, 1));
        vecs.push_back(mk(32'h500, 1,0,1,1,0, 32'h500, 32'h123, 2'b01, 0, 2'b01, 32'h0,   0,0, 2'd2));
        vecs.push_back(idle(32'h400, 1, 2'b11, 32'h80, 0, 1));
        vecs.push_back(idle(32'h500, 0, 2'b01, 32'h0, 0, 0));
        vecs.push_back(mk(32'h600, 1,1,0,0,0, 32'h600, 32'h44,  2'b01, 0, 2'b01, 32'h0,   0,0, 2'd2));
        vecs.push_back(idle(32'h400, 1, 2'b11, 32'h80, 0, 1));
        vecs.push_back(idle(32'h600, 0, 2'b01, 32'h0, 0, 0));
        vecs.push_back(mk(32'h400, 1,1,0,0,1, 32'h100, 32'h200, 2'b01, 1, 2'b11, 32'h80,  0,1, 2'd0));
        vecs.push_back(idle(32'h100, 1, 2'b10, 32'h200, 1, 0));
        vecs.push_back(mk(32'h100, 1,1,0,0,1, 32'h200, 32'h240, 2'b01, 1, 2'b10, 32'h200, 1,0, 2'd0));
        vecs.push_back(idle(32'h100, 0, 2'b01, 32'h0, 0, 0));
        vecs.push_back(idle(32'h200, 1, 2'b10, 32'h240, 1, 0));
        vecs.push_back(mk(32'h200, 0,1,0,0,0, 32'h200, 32'h0,   2'b10, 1, 2'b10, 32'h240, 1,0, 2'd1));
        vecs.push_back(idle(32'h200, 1, 2'b10, 32'h240, 1, 0));
        vecs.push_back(mk(32'h104, 1,1,0,0,1, 32'h104, 32'h1000, 2'b01, 0, 2'b01, 32'h0,  0,0, 2'd0));
        vecs.push_back(idle(32'h104, 1, 2'b10, 32'h1000, 1, 0));
        vecs.push_back(idle(32'h200, 1, 2'b10, 32'h240, 1, 0));
        vecs.push_back(mk(32'h108, 1,1,1,0,0, 32'h108, 32'h55,  2'b01, 0, 2'b01, 32'h0,   0,0, 2'd2));
        vecs.push_back(idle(32'h108, 0, 2'b01, 32'h0, 0, 0));
        vecs.push_back(idle(32'h8000_0200, 0, 2'b01, 32'h0, 0, 0));

        rst = 1'b1;
        drive_idle(32'h100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk_lookup("reset", 0, 2'b01, 32'h0, 0, 0);
        chk("reset status", {30'd0, prediction_status}, 32'd2);
        rst = 1'b0;

        exp_hits = 0;
        exp_misp = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            IF_pc = vecs[i].if_pc; EX_valid = vecs[i].v; EX_Branch = vecs[i].br;
            EX_Jump = vecs[i].jp; EX_ALUSrc = vecs[i].src; EX_taken = vecs[i].tk;
            EX_pc = vecs[i].ex_pc; EX_pc_imm = vecs[i].imm;
            EX_branch_prediction = vecs[i].bp;
            #2;
            chk_lookup($sformatf("row%0d", i), vecs[i].e_hit, vecs[i].e_bp,
                       vecs[i].e_imm, vecs[i].e_br, vecs[i].e_jmp);
            chk($sformatf("row%0d status", i), {30'd0, prediction_status}, {30'd0, vecs[i].e_ps});
            if (vecs[i].e_hit) exp_hits++;
            if (vecs[i].v && vecs[i].br && (vecs[i].e_ps < 2)) exp_misp++;
        end

        @(negedge clk);
        drive_idle(32'h200);
`ifdef BTB_PERF_CNT_EN
        #2;
        chk("lookup_cnt", lookup_cnt, vecs.size() + 1);
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("mispredict_cnt", mispredict_cnt, exp_misp);
`endif

        // Reset asserted while an allocating update is presented: reset wins.
        @(negedge clk);
        rst = 1'b1;
        IF_pc = 32'h200; EX_valid = 1; EX_Branch = 1; EX_taken = 1;
        EX_pc = 32'h10C; EX_pc_imm = 32'h700; EX_branch_prediction = 2'b01;
        #2;
        chk_lookup("in-reset", 0, 2'b01, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle(32'h10C);
        #2;
        chk_lookup("post-reset 10C", 0, 2'b01, 32'h0, 0, 0);
`ifdef BTB_PERF_CNT_EN
        chk("lookup_cnt cleared", lookup_cnt, 32'd0);
        chk("mispredict_cnt cleared", mispredict_cnt, 32'd0);
`endif
        @(negedge clk);
        IF_pc = 32'h200;
        #2;
        chk_lookup("post-reset 200", 0, 2'b01, 32'h0, 0, 0);
        @(negedge clk);
        IF_pc = 32'h104;
        #2;
        chk_lookup("post-reset 104", 0, 2'b01, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped BTB plus 2-bit bimodal predictor. It supplies the fetch next-PC logic with BTBhit, IF_branch_prediction, IF_pc_imm, IF_Branch and IF_Jump.
- It takes branch/jump resolution from EX, returns prediction_status, and trains its table.
- Sits beside the fetch unit. It is the responder end of the fetch prediction/resolution interface.

Parameters:
- ENTRIES, 64, number of BTB entries (power of two, ≥2).
- INDEX_BITS, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_BITS, 30-INDEX_BITS, tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IF_pc  in  32  fetch PC to look up
- BTBhit  out  1  valid entry with matching tag
- IF_branch_prediction  out  2  counter of hit entry; 2'b01 on miss
- IF_pc_imm  out  32  stored target; 0 on miss
- IF_Branch  out  1  hit and entry is a conditional branch
- IF_Jump  out  1  hit and entry is JAL
- EX_valid  in  1  EX holds a real (unflushed, unstalled) instruction
- EX_pc  in  32  PC of EX instruction
- EX_Branch  in  1  EX instruction is a conditional branch
- EX_Jump  in  1  EX instruction is a jump
- EX_ALUSrc  in  1  1 = JALR (never stored)
- EX_taken  in  1  branch outcome
- EX_pc_imm  in  32  resolved branch/JAL target
- EX_branch_prediction  in  2  counter value carried from IF
- prediction_status  out  2  resolution code to fetch

Behaviour:
- Index = pc[INDEX_BITS+1:2]. Tag = pc[31:INDEX_BITS+2].
- Entry fields: valid, tag, target[31:0], is_jump, ctr[1:0].
- Lookup is combinational (zero latency) from the register array on IF_pc.
  - Hit = valid && tag match.
  - IF_Branch = hit & !is_jump; IF_Jump = hit & is_jump.
- prediction_status is combinational from EX inputs. Predicted-taken = EX_branch_prediction[1].
  - 0: taken, predicted not-taken.
  - 1: not-taken, predicted taken.
  - 2: correct not-taken.
  - 3: correct taken.
  - Value is don't-care unless EX_Branch is high; drive 2 in that case.
- Update happens on the rising edge, only when EX_valid. It writes at index(EX_pc).
  - Conditional branch, tag hit: ctr saturating ±1 by EX_taken (3 stays 3, 0 stays 0). Target rewritten with EX_pc_imm when taken.
  - Conditional branch, miss, taken: allocate valid=1, tag, target=EX_pc_imm, is_jump=0, ctr=2'b10.
  - Conditional branch, miss, not taken: no write.
  - JAL (EX_Jump & !EX_ALUSrc): write valid=1, tag, target, is_jump=1, ctr=2'b11. Hit or miss, no counter training.
  - JALR (EX_Jump & EX_ALUSrc): no write.
  - Conflicting tag: overwrite (direct-mapped, no replacement policy).
- Same-cycle lookup and update on the same index: the lookup returns pre-update contents. There is no write-to-read bypass.
- Reset: all valid=0, all ctr=2'b01, targets/tags=0.
  - Outputs during and after reset: BTBhit=0, IF_Branch=0, IF_Jump=0, IF_pc_imm=0, IF_branch_prediction=2'b01.
  - Reset asserted mid-operation: the pending update that cycle is discarded; reset wins.
- EX_Branch and EX_Jump are both high: treat as illegal; Branch takes priority.

Optional Feature:
- Macro BTB_PERF_CNT_EN.
- When defined, adds three outputs:
  - lookup_cnt[31:0]: increments every cycle not in reset.
  - hit_cnt[31:0]: increments when BTBhit.
  - mispredict_cnt[31:0]: increments when EX_valid & EX_Branch & prediction_status<2.
- All three clear on rst and wrap modulo 2^32.
- When not defined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared package holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - prediction_status codes PS_MISS_T=0, PS_MISS_NT=1, PS_OK_NT=2, PS_OK_T=3;
  - reset counter value WNT.
- One sub-module, sat_counter2: combinational next-state of a 2-bit saturating counter given taken.

Test Plan:
- Reset then IF_pc=0x0000_0100 -> BTBhit=0, IF_branch_prediction=2'b01, IF_pc_imm=0.
- EX_valid, EX_Branch, EX_pc=0x100, EX_taken=1, EX_pc_imm=0x200, EX_branch_prediction=01 -> prediction_status=0. Next cycle IF_pc=0x100 gives BTBhit=1, IF_Branch=1, prediction=10, IF_pc_imm=0x200.
- Same branch resolved taken ×3 -> ctr 10→11→11 (saturates). Then not-taken with prediction 11 -> status=1, ctr=10.
- JAL at EX_pc=0x400, target 0x80 -> IF_pc=0x400 hits with IF_Jump=1, IF_Branch=0. JALR at 0x500 -> no entry created.
- ENTRIES=64: branch at 0x100 allocated, then taken branch at 0x200 (same index, different tag) -> 0x100 misses, 0x200 hits.
- Update to 0x100 and lookup of 0x100 in the same cycle -> lookup shows old (miss); next cycle shows hit. With BTB_PERF_CNT_EN, mispredict_cnt increments by 1 per status<2.
